// File: rtl/aligner_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aligner_pkg
// Description : Shared types and constants for the 10-bit comma word aligner.
// Revision    : 1.0  initial release
// ============================================================================
package aligner_pkg;

    localparam int W = 10;

    // K28.5 comma prefixes (bits a..f plus leading g), bit0 = 'a'.
    localparam logic [6:0] COMMA_NEG = 7'h7C;
    localparam logic [6:0] COMMA_POS = 7'h03;

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/comma_detect_10b.sv
`default_nettype none
// ============================================================================
// Module      : comma_detect_10b
// Description : Combinational K28.5 comma search over a 20-bit window.
//               Ten parallel 7-bit compares; the lowest matching offset wins.
// Revision    : 1.0  initial release
// ============================================================================
module comma_detect_10b
    import aligner_pkg::*;
(
    input  logic [2*W-1:0] i_window,
    output logic           o_hit,
    output logic [3:0]     o_offset
);

    logic [W-1:0] w_match;
    logic         w_unused;

    // One comparator per candidate offset, matching either disparity.
    for (genvar k = 0; k < W; k++) begin : g_cmp
        assign w_match[k] = (i_window[k +: 7] == COMMA_NEG) ||
                            (i_window[k +: 7] == COMMA_POS);
    end

    // The top window bits never start a comma at offsets 0..9.
    assign w_unused = ^i_window[2*W-1:W+6];

    // Priority encode: scanning downwards leaves the lowest hit index.
    always_comb begin
        o_hit    = |w_match;
        o_offset = 4'd0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_offset = 4'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_aligner_10b.sv
`default_nettype none
// ============================================================================
// Module      : word_aligner_10b
// Description : Bit-level K28.5 comma aligner with LOS/ACQ/SYNC lock FSM.
//               Barrel-shifts the raw deserialiser stream onto the code-group
//               boundary and drops lock on decoder-reported errors.
//               Optional macro ALIGNER_STATS_EN adds a saturating los_count.
// Revision    : 1.0  initial release
// ============================================================================
module word_aligner_10b
    import aligner_pkg::*;
#(
    parameter int ACQ_COMMAS = 3,
    parameter int ERR_LIMIT  = 4,
    parameter int GOOD_RUN   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rx_data,
    input  logic         rx_valid,
    input  logic         dec_err,
    output logic [W-1:0] aligned_data,
    output logic         aligned_valid,
    output logic         sync_status,
    output logic [3:0]   align_pos
`ifdef ALIGNER_STATS_EN
    ,
    output logic [15:0]  los_count
`endif
);

    localparam int CW_CNT = $clog2(ACQ_COMMAS + 1);
    localparam int CW_ERR = $clog2(ERR_LIMIT + 1);
    localparam int CW_GD  = $clog2(GOOD_RUN + 1);

    localparam logic [CW_CNT-1:0] C_ACQ_COMMAS = CW_CNT'(ACQ_COMMAS);
    localparam logic [CW_ERR-1:0] C_ERR_LIMIT  = CW_ERR'(ERR_LIMIT);
    localparam logic [CW_GD-1:0]  C_GOOD_RUN   = CW_GD'(GOOD_RUN);

    state_t              r_state;
    state_t              w_state_next;
    logic [W-1:0]        r_prev;
    logic [3:0]          r_pos;
    logic [3:0]          w_pos_next;
    logic [CW_CNT-1:0]   r_comma_cnt;
    logic [CW_CNT-1:0]   w_comma_next;
    logic [CW_CNT-1:0]   w_comma_inc;
    logic [CW_ERR-1:0]   r_err_cnt;
    logic [CW_ERR-1:0]   w_err_next;
    logic [CW_ERR-1:0]   w_err_inc;
    logic [CW_GD-1:0]    r_good_cnt;
    logic [CW_GD-1:0]    w_good_next;
    logic [CW_GD-1:0]    w_good_inc;
    logic                w_event;
    logic [2*W-1:0]      w_window;
    logic                w_hit;
    logic [3:0]          w_off;
    logic [W-1:0]        w_aligned;
    logic [W-1:0]        r_aligned_data;
    logic                r_aligned_valid;
    logic                r_sync;

    // Older word sits in the low half so bit0 stays the earliest serial bit.
    assign w_window = {rx_data, r_prev};

    comma_detect_10b u_detect (
        .i_window (w_window),
        .o_hit    (w_hit),
        .o_offset (w_off)
    );

    // Saturating increments; the FSM never needs values past the limits.
    assign w_comma_inc = (r_comma_cnt == C_ACQ_COMMAS) ? r_comma_cnt : r_comma_cnt + 1'b1;
    assign w_err_inc   = (r_err_cnt   == C_ERR_LIMIT)  ? r_err_cnt   : r_err_cnt   + 1'b1;
    assign w_good_inc  = (r_good_cnt  == C_GOOD_RUN)   ? r_good_cnt  : r_good_cnt  + 1'b1;

    // Lock FSM next-state and counter updates; only dec_err acts on idle cycles.
    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_comma_next = r_comma_cnt;
        w_err_next   = r_err_cnt;
        w_good_next  = r_good_cnt;
        w_event      = 1'b0;
        case (r_state)
            LOS: begin
                if (rx_valid && w_hit) begin
                    w_state_next = ACQ;
                    w_pos_next   = w_off;
                    w_comma_next = CW_CNT'(1);
                end
            end
            ACQ: begin
                if (rx_valid && w_hit) begin
                    if (w_off == r_pos) begin
                        w_comma_next = w_comma_inc;
                        if (w_comma_inc == C_ACQ_COMMAS) begin
                            w_state_next = SYNC;
                            w_err_next   = '0;
                            w_good_next  = '0;
                        end
                    end else begin
                        w_pos_next   = w_off;
                        w_comma_next = CW_CNT'(1);
                    end
                end
            end
            SYNC: begin
                w_event = dec_err || (rx_valid && w_hit && (w_off != r_pos));
                if (w_event) begin
                    w_err_next  = w_err_inc;
                    w_good_next = '0;
                    if (w_err_inc == C_ERR_LIMIT) begin
                        w_state_next = LOS;
                    end
                end else if (rx_valid) begin
                    if (w_good_inc == C_GOOD_RUN) begin
                        w_good_next = '0;
                        if (r_err_cnt != '0) begin
                            w_err_next = r_err_cnt - 1'b1;
                        end
                    end else begin
                        w_good_next = w_good_inc;
                    end
                end
            end
            default: begin
                w_state_next = LOS;
            end
        endcase
    end

    // Barrel shift uses the offset that will hold after this cycle.
    assign w_aligned = w_window[w_pos_next +: W];

    // State, counters, history word and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= LOS;
            r_prev          <= '0;
            r_pos           <= '0;
            r_comma_cnt     <= '0;
            r_err_cnt       <= '0;
            r_good_cnt      <= '0;
            r_aligned_data  <= '0;
            r_aligned_valid <= 1'b0;
            r_sync          <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pos       <= w_pos_next;
            r_comma_cnt <= w_comma_next;
            r_err_cnt   <= w_err_next;
            r_good_cnt  <= w_good_next;
            if (rx_valid) begin
                r_prev         <= rx_data;
                r_aligned_data <= w_aligned;
            end
            r_aligned_valid <= rx_valid && (w_state_next != LOS);
            r_sync          <= (w_state_next == SYNC);
        end
    end

    assign aligned_data  = r_aligned_data;
    assign aligned_valid = r_aligned_valid;
    assign sync_status   = r_sync;
    assign align_pos     = r_pos;

`ifdef ALIGNER_STATS_EN
    logic [15:0] r_los_count;

    // Count SYNC->LOS drops, holding at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_los_count <= '0;
        end else if ((r_state == SYNC) && (w_state_next == LOS) &&
                     (r_los_count != 16'hFFFF)) begin
            r_los_count <= r_los_count + 16'd1;
        end
    end

    assign los_count = r_los_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_aligner_10b.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_aligner_10b
// Description : Self-checking bench for word_aligner_10b (ALIGNER_STATS_EN
//               aware) with a behavioural reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_word_aligner_10b;

    localparam int ACQ_COMMAS = 3;
    localparam int ERR_LIMIT  = 4;
    localparam int GOOD_RUN   = 4;
    localparam int M_LOS  = 0;
    localparam int M_ACQ  = 1;
    localparam int M_SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       dec_err;
    logic [9:0] aligned_data;
    logic       aligned_valid;
    logic       sync_status;
    logic [3:0] align_pos;
`ifdef ALIGNER_STATS_EN
    logic [15:0] los_count;
`endif

    word_aligner_10b #(
        .ACQ_COMMAS (ACQ_COMMAS),
        .ERR_LIMIT  (ERR_LIMIT),
        .GOOD_RUN   (GOOD_RUN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .dec_err       (dec_err),
        .aligned_data  (aligned_data),
        .aligned_valid (aligned_valid),
        .sync_status   (sync_status),
        .align_pos     (align_pos)
`ifdef ALIGNER_STATS_EN
        ,
        .los_count     (los_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_state;
    int         m_pos;
    int         m_cnt;
    int         m_err;
    int         m_good;
    int         m_los;
    logic [9:0] m_prev;
    logic [9:0] m_data;
    bit         m_valid;
    bit         m_sync;

    // Serial bit stream feeding the deserialiser words
    bit         ser_q[$];
    int         gen_mode;
    bit         alt;
    logic [9:0] safe_groups [4] = '{10'h17C, 10'h283, 10'h2AA, 10'h155};

    function automatic int find_comma(input logic [19:0] win);
        logic [6:0] seg;
        for (int k = 0; k < 10; k++) begin
            seg = 7'((win >> k) & 20'h7F);
            if (seg == 7'h7C || seg == 7'h03) return k;
        end
        return -1;
    endfunction

    task automatic model_update(input bit rst, input bit v, input logic [9:0] d, input bit e);
        logic [19:0] win;
        int k;
        int st0;
        bit ev;
        if (rst) begin
            m_state = M_LOS; m_pos = 0; m_cnt = 0; m_err = 0; m_good = 0;
            m_prev = '0; m_data = '0; m_valid = 1'b0; m_sync = 1'b0; m_los = 0;
            return;
        end
        win = {d, m_prev};
        k   = find_comma(win);
        st0 = m_state;
        if (st0 == M_SYNC) begin
            ev = e || (v && k >= 0 && k != m_pos);
            if (ev) begin
                m_good = 0;
                m_err++;
                if (m_err >= ERR_LIMIT) begin
                    m_state = M_LOS;
                    if (m_los < 65535) m_los++;
                end
            end else if (v) begin
                m_good++;
                if (m_good == GOOD_RUN) begin
                    m_good = 0;
                    if (m_err > 0) m_err--;
                end
            end
        end else if (v && k >= 0) begin
            if (st0 == M_LOS || k != m_pos) begin
                m_state = M_ACQ; m_pos = k; m_cnt = 1;
            end else begin
                m_cnt++;
                if (m_cnt >= ACQ_COMMAS) begin
                    m_state = M_SYNC; m_err = 0; m_good = 0;
                end
            end
        end
        if (v) begin
            m_data = 10'((win >> m_pos) & 20'h3FF);
            m_prev = d;
        end
        m_valid = v && (m_state != M_LOS);
        m_sync  = (m_state == M_SYNC);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit rst);
        check("aligned_valid", 32'(aligned_valid), 32'(m_valid));
        check("sync_status", 32'(sync_status), 32'(m_sync));
        check("align_pos", 32'(align_pos), 32'(m_pos));
        if (m_valid || rst) check("aligned_data", 32'(aligned_data), 32'(m_data));
`ifdef ALIGNER_STATS_EN
        check("los_count", 32'(los_count), 32'(m_los));
`endif
    endtask

    task automatic step(input bit rst, input bit v, input logic [9:0] d, input bit e);
        reset = rst; rx_valid = v; rx_data = d; dec_err = e;
        @(posedge clk);
        model_update(rst, v, d, e);
        #1;
        check_all(rst);
    endtask

    task automatic push_group(input logic [9:0] g);
        for (int i = 0; i < 10; i++) ser_q.push_back(g[i]);
    endtask

    // Alternating filler 1,0,1,... slips the stream without forming a comma.
    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) ser_q.push_back(i % 2 == 0);
    endtask

    task automatic send(input bit e);
        logic [9:0] w;
        while (ser_q.size() < 10) begin
            if (gen_mode == 0) begin
                push_group(alt ? 10'h283 : 10'h17C);
                alt = ~alt;
            end else begin
                push_group(safe_groups[$urandom_range(0, 3)]);
            end
        end
        for (int i = 0; i < 10; i++) w[i] = ser_q.pop_front();
        step(1'b0, 1'b1, w, e);
    endtask

    task automatic restart(input int fill);
        step(1'b1, 1'b0, 10'h000, 1'b0);
        ser_q.delete();
        alt = 1'b0;
        push_fill(fill);
    endtask

    initial begin
        int r;
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; dec_err = 1'b0;
        gen_mode = 0; alt = 1'b0;

        // 1: reset held with random inputs
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 10'($urandom), 1'($urandom_range(0, 1)));
        check("rst_data", 32'(aligned_data), 32'h0);
        check("rst_pos", 32'(align_pos), 32'h0);

        // 2: aligned comma stream
        restart(0);
        repeat (3) send(1'b0);
        check("t2_presync", 32'(sync_status), 32'h0);
        send(1'b0);
        check("t2_sync", 32'(sync_status), 32'h1);
        check("t2_pos", 32'(align_pos), 32'h0);
        check("t2_data0", 32'(aligned_data), 32'h17C);
        send(1'b0);
        check("t2_data1", 32'(aligned_data), 32'h283);

        // 3: stream slipped by 3 bits
        restart(3);
        repeat (4) send(1'b0);
        check("t3_sync", 32'(sync_status), 32'h1);
        check("t3_pos", 32'(align_pos), 32'h3);
        check("t3_data", 32'(aligned_data), 32'h17C);

        // 4: four consecutive decoder errors force loss
        repeat (3) send(1'b1);
        check("t4_hold", 32'(sync_status), 32'h1);
        send(1'b1);
        check("t4_lost", 32'(sync_status), 32'h0);
        check("t4_valid", 32'(aligned_valid), 32'h0);

        // 5: sparse errors never accumulate
        restart(0);
        repeat (4) send(1'b0);
        for (int i = 0; i < 25; i++) send(i % 5 == 4);
        check("t5_sync", 32'(sync_status), 32'h1);

        // 6: re-acquire at a new offset during ACQ, then repeated loss
        restart(0);
        repeat (2) send(1'b0);
        push_fill(5);
        send(1'b0);
        check("t6_pos0", 32'(align_pos), 32'h0);
        send(1'b0);
        check("t6_pos5", 32'(align_pos), 32'h5);
        check("t6_acq", 32'(sync_status), 32'h0);
        repeat (2) send(1'b0);
        check("t6_sync", 32'(sync_status), 32'h1);
        for (int n = 1; n <= 2; n++) begin
            repeat (4) send(1'b1);
            check("t6_lost", 32'(sync_status), 32'h0);
`ifdef ALIGNER_STATS_EN
            check("t6_los_count", 32'(los_count), 32'(n));
`endif
            repeat (3) send(1'b0);
            check("t6_resync", 32'(sync_status), 32'h1);
        end

        // Randomised traffic: slips, gaps, raw words, errors, mid-run resets
        restart(0);
        gen_mode = 1;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)
                step(1'b0, 1'b0, 10'($urandom), 1'($urandom_range(0, 3) == 0));
            else if (r < 11) begin
                push_fill(int'($urandom_range(1, 9)));
                send(1'b0);
            end else if (r < 13)
                step(1'b0, 1'b1, 10'($urandom), 1'b0);
            else if (r == 13)
                step(1'b1, 1'b1, 10'($urandom), 1'b0);
            else
                send(r < 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
